btn_event: RTL and testbench
============================

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 SHALL have parameter HOLD_MS, default 500: cycles from press to first repeat event; legal range 2..1023.
REQ-002 SHALL have parameter REPEAT_MS, default 100: cycles between successive repeat events; legal range 2..1023.
REQ-003 SHALL have port CLK_1ms, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port BTN, input, 2: debounced button levels, 1 = pressed.
REQ-006 SHALL have port EVT_ACK, input, 1: consumer accepts the head event.
REQ-007 SHALL have port EVT_VALID, output, 1: an event is at the head of the queue.
REQ-008 SHALL have port EVT_BTN, output, 1: button index of the head event.
REQ-009 SHALL have port EVT_TYPE, output, 2: head event type; 00 press, 01 release, 10 repeat, 11 unused.
REQ-010 SHALL have port HELD, output, 2: per-button registered pressed state.
REQ-011 SHALL have port OVF, output, 1: sticky flag, set when any event is dropped.

Function
REQ-012 SHALL register BTN into BTN_d every cycle; rise = BTN & ~BTN_d, fall = ~BTN & BTN_d.
REQ-013 SHALL run one FSM per button with states IDLE, DELAY and RPT, plus a 10-bit cycle counter per button.
REQ-014 IDLE, on rise: SHALL go to DELAY, clear the counter, and generate a press event.
REQ-015 DELAY: SHALL increment the counter; when the counter equals HOLD_MS-1 it SHALL go to RPT, clear the counter, and generate a repeat event.
REQ-016 RPT: SHALL increment the counter; when the counter equals REPEAT_MS-1 it SHALL clear the counter and generate a repeat event.
REQ-017 DELAY or RPT, on fall: SHALL go to IDLE and generate a release event; a repeat due on the same edge SHALL be suppressed.
REQ-018 Timing: press at edge k gives the first repeat at edge k+HOLD_MS and further repeats every REPEAT_MS edges while the button stays held.
REQ-019 HELD[i] SHALL be 1 exactly when FSM i is in DELAY or RPT.
REQ-020 Events SHALL be queued in a 4-entry FIFO of 3-bit entries {btn, type[1:0]}.
REQ-021 Up to two pushes per cycle; button 0's event SHALL be enqueued ahead of button 1's.
REQ-022 Pop condition: pop SHALL occur when EVT_VALID && EVT_ACK.
REQ-023 Free space for a push SHALL be 4 - count + pop, so a push and a pop on the same cycle are legal at full.
REQ-024 Events that do not fit SHALL be dropped, button 1's first, and OVF SHALL be set; the FSMs SHALL advance regardless.
REQ-025 EVT_VALID SHALL be count != 0; EVT_BTN and EVT_TYPE SHALL be driven from the head entry and held stable until popped.
REQ-026 EVT_ACK while EVT_VALID = 0 SHALL be ignored.
REQ-027 Latency: an event generated at edge k SHALL be visible at the FIFO head after edge k when the queue was empty.
REQ-028 Pointers SHALL be 2-bit and wrap modulo 4; count SHALL be 3-bit (range 0..4).

Reset
REQ-029 When RST = 1 at an edge, SHALL set both FSMs to IDLE, counters to 0, BTN_d to 00, FIFO pointers and count to 0, and OVF to 0.
REQ-030 During reset SHALL drive EVT_VALID = 0 and HELD = 00; EVT_BTN and EVT_TYPE SHALL read 0.
REQ-031 Reset mid-operation SHALL discard queued events and in-progress hold timing.
REQ-032 A button held high through reset SHALL produce a press event at the first edge after RST deasserts.

Verification (HOLD_MS=5, REPEAT_MS=3)
REQ-033 BTN=01 held 12 cycles, EVT_ACK=1 -> press at k, repeat at k+5, k+8, k+11, release at k+12; OVF=0.
REQ-034 BTN 00 -> 11 in one cycle, EVT_ACK=0 -> two entries, {0,00} then {1,00}; EVT_VALID=1 and the head is stable.
REQ-035 EVT_ACK=0 with 5 events generated -> count=4, fifth event dropped, OVF=1 and stays 1 until RST.
REQ-036 FIFO full with a simultaneous pop and one push -> no drop, count stays 4, OVF=0.
REQ-037 BTN falls on the same edge a repeat is due -> only a release is queued.
REQ-038 RST pulsed with 3 events queued and BTN=10 held -> after reset EVT_VALID=0 for one cycle, then a single {1,00} event.

Source files
------------

// File: rtl/btn_event.sv
// btn_event: two-button press/release/auto-repeat event generator feeding a 4-deep event FIFO.
module btn_event #(
   parameter int HOLD_MS   = 500,
   parameter int REPEAT_MS = 100
) (
   input  logic       CLK_1ms,
   input  logic       RST,
   input  logic [1:0] BTN,
   input  logic       EVT_ACK,
   output logic       EVT_VALID,
   output logic       EVT_BTN,
   output logic [1:0] EVT_TYPE,
   output logic [1:0] HELD,
   output logic       OVF
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_RPT   = 2'd2;
   localparam logic [1:0] T_PRESS = 2'd0;
   localparam logic [1:0] T_REL   = 2'd1;
   localparam logic [1:0] T_RPT   = 2'd2;
   localparam logic [9:0] HOLD_END = 10'(HOLD_MS - 1);
   localparam logic [9:0] RPT_END  = 10'(REPEAT_MS - 1);
   logic [1:0] btn_q, rise, fall, ev, hld;
   logic [1:0] st_q [2];
   logic [1:0] st_d [2];
   logic [9:0] tmr_q [2];
   logic [9:0] tmr_d [2];
   logic [1:0] ev_type [2];
   logic [2:0] mem_q [4];
   logic [1:0] wr_q, wr_d, rd_q, rd_d;
   logic [2:0] cnt_q, cnt_d, free;
   logic       ovf_q, ovf_d, pop, acc0, acc1;
   assign rise = BTN & ~btn_q;
   assign fall = ~BTN & btn_q;
   // Any state other than DELAY/RPT behaves as IDLE, so a corrupted encoding self-recovers.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i]    = st_q[i];
         tmr_d[i]   = tmr_q[i] + 10'd1;
         ev[i]      = 1'b0;
         ev_type[i] = T_PRESS;
         hld[i]     = (st_q[i] == S_DELAY) || (st_q[i] == S_RPT);
         if (!hld[i]) begin
            st_d[i]  = rise[i] ? S_DELAY : S_IDLE;
            tmr_d[i] = '0;
            ev[i]    = rise[i];
         end else if (fall[i]) begin
            st_d[i]    = S_IDLE;
            tmr_d[i]   = '0;
            ev[i]      = 1'b1;
            ev_type[i] = T_REL;
         end else if (tmr_q[i] == ((st_q[i] == S_DELAY) ? HOLD_END : RPT_END)) begin
            st_d[i]    = S_RPT;
            tmr_d[i]   = '0;
            ev[i]      = 1'b1;
            ev_type[i] = T_RPT;
         end
      end
   end
   // Button 0 claims free space first; a pop this cycle frees a slot for the pushes.
   always_comb begin
      pop   = EVT_VALID & EVT_ACK;
      free  = 3'd4 - cnt_q + {2'b0, pop};
      acc0  = ev[0] && (free != 3'd0);
      acc1  = ev[1] && (free > {2'b0, acc0});
      wr_d  = wr_q + {1'b0, acc0} + {1'b0, acc1};
      rd_d  = rd_q + {1'b0, pop};
      cnt_d = cnt_q + {2'b0, acc0} + {2'b0, acc1} - {2'b0, pop};
      ovf_d = ovf_q | (ev[0] & ~acc0) | (ev[1] & ~acc1);
   end
   always_ff @(posedge CLK_1ms) begin
      if (RST) begin
         btn_q <= 2'b00;
         st_q  <= '{default: S_IDLE};
         tmr_q <= '{default: 10'd0};
         wr_q  <= 2'd0;
         rd_q  <= 2'd0;
         cnt_q <= 3'd0;
         ovf_q <= 1'b0;
      end else begin
         btn_q <= BTN;
         st_q  <= st_d;
         tmr_q <= tmr_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (acc0) mem_q[wr_q] <= {1'b0, ev_type[0]};
         if (acc1) mem_q[wr_q + {1'b0, acc0}] <= {1'b1, ev_type[1]};
      end
   end
   assign EVT_VALID           = ~RST & (cnt_q != 3'd0);
   assign {EVT_BTN, EVT_TYPE} = EVT_VALID ? mem_q[rd_q] : 3'd0;
   assign HELD                = RST ? 2'b00 : hld;
   assign OVF                 = ovf_q;
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: random and directed stimulus against a timing-arithmetic reference model with a scoreboard queue.
module tb_btn_event;
   localparam int HOLD = 5;
   localparam int REP  = 3;
   logic       clk = 1'b0;
   logic       rst, ack, evt_valid, evt_btn, ovf;
   logic [1:0] btn, evt_type, held;
   int         errors = 0;
   int         checks = 0;
   int         pops   = 0;
   logic [2:0] exp_q [$];
   bit   [1:0] m_btn_d;
   bit         m_pr [2];
   int         m_k [2];
   int         n = 0;
   int         m_cnt;
   bit         m_ovf;
   btn_event #(.HOLD_MS(HOLD), .REPEAT_MS(REP)) dut (
      .CLK_1ms(clk), .RST(rst), .BTN(btn), .EVT_ACK(ack),
      .EVT_VALID(evt_valid), .EVT_BTN(evt_btn), .EVT_TYPE(evt_type),
      .HELD(held), .OVF(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask
   // Reference: repeats fall at press edge + HOLD + j*REP; the queue holds at most 4 events.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_btn_d = 2'b00;
         m_pr    = '{0, 0};
         m_cnt   = 0;
         m_ovf   = 0;
      end else begin
         int  free;
         bit  e;
         logic [1:0] t;
         if (m_cnt != 0 && ack) m_cnt--;
         free = 4 - m_cnt;
         for (int i = 0; i < 2; i++) begin
            e = 0;
            t = 2'd0;
            if (!m_pr[i]) begin
               if (btn[i] && !m_btn_d[i]) begin e = 1; t = 2'd0; m_pr[i] = 1; m_k[i] = n; end
            end else if (!btn[i]) begin
               e = 1; t = 2'd1; m_pr[i] = 0;
            end else if (n - m_k[i] >= HOLD && (n - m_k[i] - HOLD) % REP == 0) begin
               e = 1; t = 2'd2;
            end
            if (e) begin
               if (free > 0) begin
                  exp_q.push_back({i[0], t});
                  free--;
                  m_cnt++;
               end else m_ovf = 1;
            end
         end
         m_btn_d = btn;
      end
      n++;
   end
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", evt_valid, 0);
         chk("rst_held", held, 0);
         chk("rst_head", {evt_btn, evt_type}, 0);
      end else begin
         chk("valid", evt_valid, exp_q.size() != 0);
         chk("held", held, {m_pr[1], m_pr[0]});
         chk("ovf", ovf, m_ovf);
         if (evt_valid && exp_q.size() == 0) begin
            errors++;
            $display("FAIL head: got %0d with no event expected at %0t", {evt_btn, evt_type}, $time);
         end else if (evt_valid && ack) begin
            chk("pop_head", {evt_btn, evt_type}, exp_q.pop_front());
            pops++;
         end else if (evt_valid) chk("hold_head", {evt_btn, evt_type}, exp_q[0]);
      end
   end
   task automatic cyc(input logic r, input logic [1:0] b, input logic a, input int cnt);
      for (int c = 0; c < cnt; c++) begin
         rst = r; btn = b; ack = a;
         @(posedge clk);
         #2;
      end
   endtask
   initial begin
      cyc(1, 2'b00, 0, 2);
      cyc(0, 2'b01, 1, 12);
      cyc(0, 2'b00, 1, 3);
      cyc(0, 2'b11, 0, 12);
      cyc(0, 2'b00, 0, 2);
      cyc(0, 2'b00, 1, 6);
      cyc(1, 2'b00, 0, 1);
      cyc(0, 2'b01, 1, 5);
      cyc(0, 2'b00, 1, 3);
      cyc(0, 2'b01, 0, 1);
      cyc(0, 2'b00, 0, 1);
      cyc(0, 2'b01, 0, 1);
      cyc(0, 2'b00, 0, 1);
      cyc(0, 2'b01, 1, 1);
      cyc(0, 2'b01, 0, 2);
      cyc(0, 2'b00, 1, 6);
      cyc(0, 2'b11, 0, 6);
      cyc(0, 2'b10, 0, 1);
      cyc(1, 2'b10, 0, 1);
      cyc(0, 2'b10, 1, 4);
      cyc(0, 2'b00, 1, 3);
      begin
         logic [1:0] b = 2'b00;
         int ap = 2;
         for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) ap = $urandom_range(0, 4);
            for (int i = 0; i < 2; i++) if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            cyc($urandom_range(0, 199) == 0, b, $urandom_range(0, 3) < ap, 1);
         end
      end
      cyc(0, 2'b00, 1, 8);
      checks++;
      if (pops < 50) begin
         errors++;
         $display("FAIL pop_count: got %0d handshakes required at least 50", pops);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
